// File: rtl/if_fetch_unit.sv
// if_fetch_unit
//   Instruction fetch stage. Holds the program counter, issues one
//   instruction-memory read per cycle when the fetch queue has room, and
//   captures each response into a small FIFO that feeds decode.
//
// Parameters
//   XLEN     PC / instruction width in bits (>= 16)
//   QDEPTH   fetch-queue entries (power of 2, >= 2)
//   RESET_PC byte address fetched first after reset
//
// Ports
//   clk         clock, all state updates on posedge
//   reset       synchronous active-high reset
//   pcsrc       redirect request (taken branch / jump)
//   if_a        redirect target byte address
//   imem_req    instruction-memory read strobe
//   imem_addr   read byte address (current PC)
//   imem_rdata  read data, valid one cycle after imem_req
//   id_valid    queue head valid toward decode
//   id_ready    decode accepts head
//   id_npc      fetch address of head + 4 (0 when id_valid = 0)
//   instrout    head instruction word (0 when id_valid = 0)
//   fq_count    queue occupancy
module if_fetch_unit #(
  parameter int unsigned       XLEN     = 32,
  parameter int unsigned       QDEPTH   = 4,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pcsrc,
  input  logic [XLEN-1:0]              if_a,
  output logic                         imem_req,
  output logic [XLEN-1:0]              imem_addr,
  input  logic [XLEN-1:0]              imem_rdata,
  output logic                         id_valid,
  input  logic                         id_ready,
  output logic [XLEN-1:0]              id_npc,
  output logic [XLEN-1:0]              instrout,
  output logic [$clog2(QDEPTH+1)-1:0]  fq_count
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam logic [CW:0] QD = (CW + 1)'(QDEPTH);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] issued_pc;
  logic            inflight;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic [XLEN-1:0] q_npc [QDEPTH];
  logic [XLEN-1:0] q_ins [QDEPTH];

  logic            deq;
  logic            enq;
  logic [CW:0]     occ_after;

  // Occupancy counts the in-flight response as already queued, so a
  // request is only issued when its data is guaranteed a slot.
  always_comb begin
    id_valid  = !reset && !pcsrc && (count != '0);
    deq       = id_valid && id_ready;
    enq       = !reset && !pcsrc && inflight;
    occ_after = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, deq};
    imem_req  = !reset && !pcsrc && (occ_after < QD);
    imem_addr = pc;
    fq_count  = count;
    id_npc    = id_valid ? q_npc[rd_ptr] : '0;
    instrout  = id_valid ? q_ins[rd_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      issued_pc <= '0;
      inflight  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else if (pcsrc) begin
      // Redirect flushes the queue and squashes any outstanding response.
      pc        <= {if_a[XLEN-1:2], 2'b00};
      issued_pc <= '0;
      inflight  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        pc        <= pc + XLEN'(4);
        issued_pc <= pc;
      end
      if (enq) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage needs no reset; entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_npc[wr_ptr] <= issued_pc + XLEN'(4);
      q_ins[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit
//   Scoreboard bench for if_fetch_unit (XLEN=32, QDEPTH=4, RESET_PC=0).
//   Instruction memory returns the request address as data, one cycle later.
//   Stimulus pushes expected {npc, instr} pairs; a negedge monitor pops and
//   compares on every decode transfer.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcsrc;
  logic [31:0] if_a;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_npc;
  logic [31:0] instrout;
  logic [2:0]  fq_count;

  int vectors = 0;
  int errors  = 0;
  int pops    = 0;
  int p0;

  logic [31:0] sb_npc [$];
  logic [31:0] sb_ins [$];

  if_fetch_unit #(
    .XLEN     (32),
    .QDEPTH   (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pcsrc      (pcsrc),
    .if_a       (if_a),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_npc     (id_npc),
    .instrout   (instrout),
    .fq_count   (fq_count)
  );

  always #5 clk = ~clk;

  // Memory: data = address when requested, recognisable garbage otherwise.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? imem_addr : 32'hBAD0_BAD0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_restart(input logic [31:0] start);
    logic [31:0] a;
    sb_npc.delete();
    sb_ins.delete();
    for (int i = 0; i < 64; i++) begin
      a = start + 32'(4 * i);
      sb_ins.push_back(a);
      sb_npc.push_back(a + 32'd4);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (id_valid === 1'b1 && id_ready === 1'b1) begin
      pops++;
      if (sb_ins.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL sb_empty: got instr 0x%08h with no expected entry", instrout);
      end else begin
        chk("instrout", instrout, sb_ins.pop_front());
        chk("id_npc", id_npc, sb_npc.pop_front());
      end
    end else if (id_valid === 1'b0) begin
      chk("idle_outs", instrout | id_npc, 32'h0);
    end
  end

  initial begin
    reset    = 1'b1;
    pcsrc    = 1'b0;
    if_a     = '0;
    id_ready = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_count", 32'(fq_count), 32'd0);
    chk("rst_instr", instrout, 32'd0);
    chk("rst_npc", id_npc, 32'd0);

    // Basic stream from RESET_PC
    sb_restart(32'h0);
    reset    = 1'b0;
    id_ready = 1'b1;
    #1;
    chk("a_req0", 32'(imem_req), 32'd1);
    chk("a_addr0", imem_addr, 32'h0);
    chk("a_valid0", 32'(id_valid), 32'd0);
    step();
    chk("a_addr1", imem_addr, 32'h4);
    chk("a_valid1", 32'(id_valid), 32'd0);
    step();
    chk("a_addr2", imem_addr, 32'h8);
    chk("a_valid2", 32'(id_valid), 32'd1);
    chk("a_instr2", instrout, 32'h0);
    chk("a_npc2", id_npc, 32'h4);
    p0 = pops;
    repeat (6) step();
    chk("a_rate", 32'(pops - p0), 32'd6);
    chk("a_addr8", imem_addr, 32'h20);

    // Redirect with three entries queued and one response in flight
    id_ready = 1'b0;
    step();
    step();
    chk("c_count3", 32'(fq_count), 32'd3);
    pcsrc = 1'b1;
    if_a  = 32'h0000_0103;
    #1;
    chk("c_valid_redir", 32'(id_valid), 32'd0);
    chk("c_req_redir", 32'(imem_req), 32'd0);
    sb_restart(32'h100);
    step();
    pcsrc    = 1'b0;
    id_ready = 1'b1;
    #1;
    chk("c_count0", 32'(fq_count), 32'd0);
    chk("c_addr", imem_addr, 32'h100);
    chk("c_req", 32'(imem_req), 32'd1);
    chk("c_valid_s3", 32'(id_valid), 32'd0);
    step();
    chk("c_valid_s4", 32'(id_valid), 32'd0);
    step();
    chk("c_valid_s5", 32'(id_valid), 32'd1);
    chk("c_instr_s5", instrout, 32'h100);
    chk("c_npc_s5", id_npc, 32'h104);
    repeat (4) step();

    // Stall: queue saturates, nothing lost, then continuous stream
    id_ready = 1'b0;
    p0 = pops;
    repeat (10) step();
    chk("b_count_sat", 32'(fq_count), 32'd4);
    chk("b_req_low", 32'(imem_req), 32'd0);
    chk("b_no_pops", 32'(pops - p0), 32'd0);
    id_ready = 1'b1;
    p0 = pops;
    repeat (12) step();
    chk("b_rate", 32'(pops - p0), 32'd12);

    // Redirect with id_ready=1 and queue non-empty, target wraps PC
    chk("d_count_pre", 32'(fq_count), 32'd3);
    pcsrc = 1'b1;
    if_a  = 32'hFFFF_FFFC;
    #1;
    chk("d_valid_redir", 32'(id_valid), 32'd0);
    chk("d_req_redir", 32'(imem_req), 32'd0);
    p0 = pops;
    sb_restart(32'hFFFF_FFFC);
    step();
    pcsrc = 1'b0;
    #1;
    chk("d_no_deq", 32'(pops - p0), 32'd0);
    chk("d_count0", 32'(fq_count), 32'd0);
    chk("d_addr_top", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("d_addr_wrap", imem_addr, 32'h0);
    step();
    chk("d_valid", 32'(id_valid), 32'd1);
    chk("d_instr", instrout, 32'hFFFF_FFFC);
    chk("d_npc_wrap", id_npc, 32'h0);
    repeat (6) step();

    // Reset mid-operation
    chk("e_req_pre", 32'(imem_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("e_req_forced", 32'(imem_req), 32'd0);
    chk("e_valid_forced", 32'(id_valid), 32'd0);
    sb_restart(32'h0);
    step();
    reset = 1'b0;
    #1;
    chk("e_count0", 32'(fq_count), 32'd0);
    chk("e_valid0", 32'(id_valid), 32'd0);
    chk("e_addr", imem_addr, 32'h0);
    chk("e_req", 32'(imem_req), 32'd1);
    step();
    chk("e_valid1", 32'(id_valid), 32'd0);
    step();
    chk("e_valid2", 32'(id_valid), 32'd1);
    chk("e_instr2", instrout, 32'h0);
    chk("e_npc2", id_npc, 32'h4);
    p0 = pops;
    repeat (5) step();
    chk("e_rate", 32'(pops - p0), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
